// File: rtl/change_dispenser.sv
// Change dispenser: queues coin-count requests and pays them out one 5-unit coin at a time
// through a hopper (timed eject pulse, then wait for coin-sense confirmation).
module change_dispenser #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned PULSE_W    = 3,
    parameter int unsigned TIMEOUT    = 15,
    parameter int unsigned GAP        = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       chg_valid,
    input  logic [1:0] change,
    input  logic       coin_sense,
    input  logic       fault_clr,
    output logic       coin_eject,
    output logic       busy,
    output logic       full,
    output logic       ovf,
    output logic       fault,
    output logic [7:0] coins_out
);

    localparam int unsigned AW    = $clog2(FIFO_DEPTH);
    localparam int unsigned CW    = AW + 1;
    localparam int unsigned TMAX0 = (PULSE_W > GAP) ? PULSE_W : GAP;
    localparam int unsigned TMAX  = (TIMEOUT > TMAX0) ? TIMEOUT : TMAX0;
    localparam int unsigned TW    = $clog2(TMAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_EJECT,
        S_WAIT,
        S_GAP,
        S_FAULT
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [1:0]      rem_q, rem_d;
    logic [7:0]      coins_q, coins_d;
    logic [1:0]      mem_q [FIFO_DEPTH];
    logic [1:0]      mem_d [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            coin_eject_q, coin_eject_d;
    logic            busy_q, busy_d;
    logic            full_q, full_d;
    logic            ovf_q, ovf_d;
    logic            fault_q, fault_d;

    logic            push, pop, push_ok, fifo_full;

    // Request FIFO; a push into a full FIFO is still taken when the head pops that cycle
    always_comb begin
        push      = chg_valid && (change != 2'b00);
        pop       = (state_q == S_IDLE) && (count_q != '0);
        fifo_full = (count_q == CW'(FIFO_DEPTH));
        push_ok   = push && (!fifo_full || pop);
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = change;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Dispense sequencer: one shared timer serves the eject, wait and gap phases
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        rem_d   = rem_q;
        coins_d = coins_q;
        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    state_d = S_EJECT;
                    rem_d   = mem_q[rd_ptr_q];
                    timer_d = '0;
                end
            end
            S_EJECT: begin
                if (timer_q == TW'(PULSE_W - 1)) begin
                    state_d = S_WAIT;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_WAIT: begin
                // Sense has priority over an expiring timeout
                if (coin_sense) begin
                    coins_d = coins_q + 8'd1;
                    rem_d   = rem_q - 2'd1;
                    state_d = S_GAP;
                    timer_d = '0;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    state_d = S_FAULT;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_GAP: begin
                if (timer_q == TW'(GAP - 1)) begin
                    timer_d = '0;
                    state_d = (rem_q != 2'd0) ? S_EJECT : S_IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_FAULT: begin
                if (fault_clr) begin
                    state_d = S_EJECT;
                    timer_d = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                timer_d = '0;
            end
        endcase
    end

    // Moore outputs registered from next state so they line up with the state register
    always_comb begin
        coin_eject_d = (state_d == S_EJECT);
        fault_d      = (state_d == S_FAULT);
        busy_d       = (state_d != S_IDLE) || (count_d != '0);
        full_d       = (count_d == CW'(FIFO_DEPTH));
        ovf_d        = push && !push_ok;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            timer_q      <= '0;
            rem_q        <= '0;
            coins_q      <= '0;
            mem_q        <= '{default: '0};
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            coin_eject_q <= 1'b0;
            busy_q       <= 1'b0;
            full_q       <= 1'b0;
            ovf_q        <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            rem_q        <= rem_d;
            coins_q      <= coins_d;
            mem_q        <= mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            coin_eject_q <= coin_eject_d;
            busy_q       <= busy_d;
            full_q       <= full_d;
            ovf_q        <= ovf_d;
            fault_q      <= fault_d;
        end
    end

    assign coin_eject = coin_eject_q;
    assign busy       = busy_q;
    assign full       = full_q;
    assign ovf        = ovf_q;
    assign fault      = fault_q;
    assign coins_out  = coins_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: table of single-request dispenses plus hand-written
// overflow, fault/retry, mid-dispense reset and coin-counter wrap sequences.
module tb_change_dispenser;

    logic       clk = 1'b0;
    logic       rst;
    logic       chg_valid;
    logic [1:0] change;
    logic       coin_sense;
    logic       fault_clr;
    logic       coin_eject;
    logic       busy;
    logic       full;
    logic       ovf;
    logic       fault;
    logic [7:0] coins_out;

    change_dispenser dut (
        .clk        (clk),
        .rst        (rst),
        .chg_valid  (chg_valid),
        .change     (change),
        .coin_sense (coin_sense),
        .fault_clr  (fault_clr),
        .coin_eject (coin_eject),
        .busy       (busy),
        .full       (full),
        .ovf        (ovf),
        .fault      (fault),
        .coins_out  (coins_out)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic [1:0] chg;
        int         delay;
        int         exp_ejects;
        int         exp_high;
        int         exp_busy;
        int         exp_coins;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst        = 1'b1;
        chg_valid  = 1'b0;
        change     = 2'b00;
        coin_sense = 1'b0;
        fault_clr  = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic push(input logic [1:0] c);
        @(negedge clk);
        chg_valid = 1'b1;
        change    = c;
        @(negedge clk);
        chg_valid = 1'b0;
        change    = 2'b00;
    endtask

    task automatic wait_eject(input logic level, input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (coin_eject != level && n < 200);
        if (coin_eject != level) check(name, int'(coin_eject), int'(level));
    endtask

    task automatic wait_idle(input int bound, input string name);
        int n;
        n = 0;
        while (busy && n < bound) begin
            @(negedge clk);
            n++;
        end
        if (busy) check(name, int'(busy), 0);
    endtask

    initial begin
        int running;
        int ejects, high, busy_cnt, seen, cyc, wcnt, cnt, sent;
        logic prev, in_wait;

        rst        = 1'b1;
        chg_valid  = 1'b0;
        change     = 2'b00;
        coin_sense = 1'b0;
        fault_clr  = 1'b0;

        // {change, sense delay into WAIT, ejects, eject-high cycles, busy cycles, coins}
        vecs[0] = '{2'b01, 0,  1, 3, 7,  1};
        vecs[1] = '{2'b11, 0,  3, 9, 19, 3};
        vecs[2] = '{2'b10, 4,  2, 6, 21, 2};
        vecs[3] = '{2'b01, 14, 1, 3, 21, 1};
        vecs[4] = '{2'b00, 0,  0, 0, 0,  0};

        do_reset();
        check("rst_eject", int'(coin_eject), 0);
        check("rst_busy",  int'(busy), 0);
        check("rst_full",  int'(full), 0);
        check("rst_ovf",   int'(ovf), 0);
        check("rst_fault", int'(fault), 0);
        check("rst_coins", int'(coins_out), 0);

        running = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chg_valid = 1'b1;
            change    = vecs[i].chg;
            ejects = 0; high = 0; busy_cnt = 0; seen = 0; cyc = 0; wcnt = 0;
            prev = 1'b0; in_wait = 1'b0;
            do begin
                @(negedge clk);
                chg_valid  = 1'b0;
                change     = 2'b00;
                coin_sense = 1'b0;
                cyc++;
                if (coin_eject && !prev) ejects++;
                if (coin_eject) high++;
                if (busy) busy_cnt++;
                if (ovf || fault) seen = 1;
                if (prev && !coin_eject) begin
                    in_wait = 1'b1;
                    wcnt    = 0;
                end
                if (in_wait) begin
                    if (wcnt == vecs[i].delay) begin
                        coin_sense = 1'b1;
                        in_wait    = 1'b0;
                    end
                    wcnt++;
                end
                prev = coin_eject;
            end while (busy && cyc < 400);
            coin_sense = 1'b0;
            running += vecs[i].exp_coins;
            if (busy) check($sformatf("vec%0d_timeout", i), 1, 0);
            check($sformatf("vec%0d_ejects", i), ejects, vecs[i].exp_ejects);
            check($sformatf("vec%0d_eject_cycles", i), high, vecs[i].exp_high);
            check($sformatf("vec%0d_busy_cycles", i), busy_cnt, vecs[i].exp_busy);
            check($sformatf("vec%0d_ovf_fault", i), seen, 0);
            check($sformatf("vec%0d_coins", i), int'(coins_out), running);
        end

        // Overflow: burst of five while the first request is ejecting
        do_reset();
        coin_sense = 1'b1;
        push(2'b01);
        wait_eject(1'b1, "ovf_first_eject");
        for (int k = 0; k < 5; k++) begin
            chg_valid = 1'b1;
            change    = 2'b01;
            @(negedge clk);
            if (k == 2) check("ovf_full_at3", int'(full), 0);
            if (k == 3) check("ovf_full_at4", int'(full), 1);
            if (k == 4) begin
                check("ovf_pulse", int'(ovf), 1);
                check("ovf_full_held", int'(full), 1);
            end
        end
        chg_valid = 1'b0;
        change    = 2'b00;
        @(negedge clk);
        check("ovf_one_cycle", int'(ovf), 0);
        wait_idle(300, "ovf_idle_timeout");
        check("ovf_coins", int'(coins_out), 5);

        // Fault: second coin of a 2-coin request never sensed, then retried
        do_reset();
        push(2'b10);
        wait_eject(1'b1, "flt_eject1");
        wait_eject(1'b0, "flt_eject1_end");
        coin_sense = 1'b1;
        @(negedge clk);
        coin_sense = 1'b0;
        wait_eject(1'b1, "flt_eject2");
        wait_eject(1'b0, "flt_eject2_end");
        cnt = 0;
        while (!fault && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        check("flt_wait_cycles", cnt, 15);
        check("flt_coins", int'(coins_out), 1);
        check("flt_eject_low", int'(coin_eject), 0);
        fault_clr  = 1'b1;
        coin_sense = 1'b1;
        @(negedge clk);
        fault_clr = 1'b0;
        check("flt_clr_fault", int'(fault), 0);
        check("flt_retry_eject", int'(coin_eject), 1);
        wait_idle(100, "flt_idle_timeout");
        check("flt_retry_coins", int'(coins_out), 2);
        check("flt_end_fault", int'(fault), 0);
        fault_clr = 1'b1;
        @(negedge clk);
        fault_clr = 1'b0;
        check("flt_clr_idle_busy", int'(busy), 0);
        check("flt_clr_idle_eject", int'(coin_eject), 0);

        // Reset during the second eject of a 3-coin request
        do_reset();
        coin_sense = 1'b1;
        push(2'b11);
        wait_eject(1'b1, "mrst_eject1");
        wait_eject(1'b0, "mrst_eject1_end");
        wait_eject(1'b1, "mrst_eject2");
        check("mrst_pre_coins", int'(coins_out), 1);
        #2 rst = 1'b1;
        #1;
        check("mrst_eject", int'(coin_eject), 0);
        check("mrst_busy", int'(busy), 0);
        check("mrst_coins", int'(coins_out), 0);
        @(negedge clk);
        rst = 1'b0;
        high = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (coin_eject || busy) high++;
        end
        check("mrst_quiet_after", high, 0);

        // coins_out wrap 255 -> 0
        do_reset();
        coin_sense = 1'b1;
        sent = 0;
        cyc  = 0;
        seen = 0;
        while (sent < 255 && cyc < 5000) begin
            @(negedge clk);
            cyc++;
            chg_valid = 1'b0;
            change    = 2'b00;
            if (ovf) seen = 1;
            if (!full) begin
                chg_valid = 1'b1;
                change    = 2'b01;
                sent++;
            end
        end
        @(negedge clk);
        chg_valid = 1'b0;
        change    = 2'b00;
        wait_idle(3000, "wrap_idle_timeout");
        check("wrap_no_ovf", seen, 0);
        check("wrap_coins_255", int'(coins_out), 255);
        push(2'b01);
        wait_idle(100, "wrap_last_timeout");
        check("wrap_coins_0", int'(coins_out), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
